uart_rx_ctrl: RTL and testbench

Receive-side controller placed between `uart_rx` and the system bus. It drives the receiver enable and converts the receiver's level-style `recv_valid`/`break` outputs into single byte events. Received bytes are buffered in a small FIFO behind a valid/ready stream. The block also reports break, overrun and inter-frame line-idle status to software.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   BYTE_W     : width of a received character
//   rx_state_e : receive controller states (OFF / RUN / DRAIN)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO for received characters, with extended-pointer full/empty detect.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : write request and byte
//   pop             : read request (ignored when empty)
//   flush           : empty the FIFO; wins over push and pop in the same cycle
//   head_data       : entry at the read pointer
//   full, empty     : occupancy flags
//   level           : current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [BYTE_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic [BYTE_W-1:0]   mem_r [DEPTH];
  logic                pop_ok_s;
  logic                write_en_s;

  // Occupancy flags: pointers carry one extra wrap bit.
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign level = wr_ptr_r - rd_ptr_r;
  assign head_data = mem_r[rd_ptr_r[AW-1:0]];

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign pop_ok_s   = pop && !empty;
  assign write_en_s = push && (!full || pop_ok_s);

  // Pointer and storage update; flush returns both pointers to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (write_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller between uart_rx and the system bus. Turns the
// receiver's level-style recv_valid/break into single byte events on the
// falling edge of recv_valid, buffers bytes in a FIFO behind a valid/ready
// stream and reports break, overrun and inter-frame idle status.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   ctrl_enable / ctrl_flush         : receive enable level / FIFO flush pulse
//   status_clear                     : clears break_seen and overrun_count
//   uart_recv_en                     : receiver enable (state != OFF)
//   uart_recv_valid/break/recv_data  : receiver outputs
//   rx_data, rx_valid, rx_ready      : byte stream out
//   fifo_level                       : FIFO occupancy
//   break_seen, overrun_count        : sticky break flag, saturating drop count
//   line_idle                        : one-cycle pulse after a quiet period
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int IDLE_CYCLES = 200000,
  parameter bit DROP_BREAK  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ctrl_enable,
  input  logic                          ctrl_flush,
  input  logic                          status_clear,
  output logic                          uart_recv_en,
  input  logic                          uart_recv_valid,
  input  logic                          uart_break,
  input  logic [BYTE_W-1:0]             uart_recv_data,
  output logic [BYTE_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          break_seen,
  output logic [7:0]                    overrun_count,
  output logic                          line_idle
);

  localparam logic [23:0] IDLE_C = IDLE_CYCLES[23:0];

  logic                valid_q;
  logic                break_q;
  logic [BYTE_W-1:0]   data_q;

  rx_state_e           state_r;
  rx_state_e           state_next_s;
  logic                uart_recv_en_r;
  logic                break_seen_r;
  logic [7:0]          overrun_count_r;
  logic [23:0]         idle_cnt_r;
  logic                armed_r;
  logic                line_idle_r;

  logic                event_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic                overrun_s;

  // Data and break are only settled at the end of the stop bit, so the byte is taken on the falling edge.
  assign event_s   = valid_q && !uart_recv_valid;
  assign accept_s  = event_s && (state_r != OFF);
  assign push_s    = accept_s && !(break_q && DROP_BREAK);
  assign rx_valid  = !empty_s;
  assign pop_s     = rx_valid && rx_ready;
  assign overrun_s = push_s && full_s && !pop_s && !ctrl_flush;

  assign uart_recv_en  = uart_recv_en_r;
  assign break_seen    = break_seen_r;
  assign overrun_count = overrun_count_r;
  assign line_idle     = line_idle_r;

  // Input registers for the receiver outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      break_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= uart_recv_valid;
      break_q <= uart_break;
      data_q  <= uart_recv_data;
    end
  end

  // State register; the receiver enable is registered from the next state so it tracks the state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= OFF;
      uart_recv_en_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      uart_recv_en_r <= (state_next_s != OFF);
    end
  end

  // Next-state logic; DRAIN keeps the receiver on until the byte in its stop bit completes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OFF: begin
        if (ctrl_enable) state_next_s = RUN;
        else             state_next_s = OFF;
      end
      RUN: begin
        if (ctrl_enable)  state_next_s = RUN;
        else if (valid_q) state_next_s = DRAIN;
        else              state_next_s = OFF;
      end
      DRAIN: begin
        if (ctrl_enable)  state_next_s = RUN;
        else if (event_s) state_next_s = OFF;
        else              state_next_s = DRAIN;
      end
      default: state_next_s = OFF;
    endcase
  end

  // Break flag: a new break wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      break_seen_r <= 1'b0;
    end else if (accept_s && break_q) begin
      break_seen_r <= 1'b1;
    end else if (status_clear) begin
      break_seen_r <= 1'b0;
    end
  end

  // Overrun counter: clear wins over a simultaneous drop; saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_count_r <= 8'd0;
    end else if (status_clear) begin
      overrun_count_r <= 8'd0;
    end else if (overrun_s && (overrun_count_r != 8'hFF)) begin
      overrun_count_r <= overrun_count_r + 8'd1;
    end
  end

  // Idle detector: armed by a byte, fires once when the quiet count hits IDLE_CYCLES, then disarms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_r  <= 24'd0;
      armed_r     <= 1'b0;
      line_idle_r <= 1'b0;
    end else if (state_r == OFF) begin
      idle_cnt_r  <= 24'd0;
      line_idle_r <= 1'b0;
    end else if (accept_s) begin
      idle_cnt_r  <= 24'd0;
      armed_r     <= 1'b1;
      line_idle_r <= 1'b0;
    end else if (armed_r && (idle_cnt_r == IDLE_C)) begin
      idle_cnt_r  <= 24'd0;
      armed_r     <= 1'b0;
      line_idle_r <= 1'b1;
    end else if (armed_r) begin
      idle_cnt_r  <= idle_cnt_r + 24'd1;
      line_idle_r <= 1'b0;
    end else begin
      line_idle_r <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (data_q),
    .pop       (pop_s),
    .flush     (ctrl_flush),
    .head_data (rx_data),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. Two instances share all stimulus:
//   dut    : FIFO_DEPTH 8, IDLE_CYCLES 50, break events dropped
//   dut_nb : FIFO_DEPTH 8, IDLE_CYCLES 50, break events pushed as 0x00
// Inputs change 1 ns after the rising edge; outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_flush = 1'b0;
  logic        status_clear = 1'b0;
  logic        uart_recv_valid = 1'b0;
  logic        uart_break = 1'b0;
  logic [7:0]  uart_recv_data = 8'h00;
  logic        rx_ready = 1'b0;

  logic        uart_recv_en, rx_valid, break_seen, line_idle;
  logic [7:0]  rx_data, overrun_count;
  logic [3:0]  fifo_level;

  logic        nb_recv_en, nb_rx_valid, nb_break_seen, nb_line_idle;
  logic [7:0]  nb_rx_data, nb_overrun_count;
  logic [3:0]  nb_fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count every cycle in which line_idle is high and remember when it was.
  always @(negedge clk) begin
    if (line_idle === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc;
    end
  end

  uart_rx_ctrl #(.FIFO_DEPTH(8), .IDLE_CYCLES(50), .DROP_BREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable), .ctrl_flush(ctrl_flush),
    .status_clear(status_clear), .uart_recv_en(uart_recv_en),
    .uart_recv_valid(uart_recv_valid), .uart_break(uart_break),
    .uart_recv_data(uart_recv_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_level(fifo_level), .break_seen(break_seen),
    .overrun_count(overrun_count), .line_idle(line_idle)
  );

  uart_rx_ctrl #(.FIFO_DEPTH(8), .IDLE_CYCLES(50), .DROP_BREAK(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable), .ctrl_flush(ctrl_flush),
    .status_clear(status_clear), .uart_recv_en(nb_recv_en),
    .uart_recv_valid(uart_recv_valid), .uart_break(uart_break),
    .uart_recv_data(uart_recv_data), .rx_data(nb_rx_data), .rx_valid(nb_rx_valid),
    .rx_ready(rx_ready), .fifo_level(nb_fifo_level), .break_seen(nb_break_seen),
    .overrun_count(nb_overrun_count), .line_idle(nb_line_idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds recv_valid for 5 cycles, then drops it; returns inside the event cycle.
  task automatic send_byte(input logic [7:0] d, input logic brk);
    uart_recv_data  = d;
    uart_break      = brk;
    uart_recv_valid = 1'b1;
    repeat (5) tick();
    uart_recv_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".recv_en"},  {31'd0, uart_recv_en}, 32'd0);
    check({tag, ".rx_valid"}, {31'd0, rx_valid},     32'd0);
    check({tag, ".rx_data"},  {24'd0, rx_data},      32'd0);
    check({tag, ".level"},    {28'd0, fifo_level},   32'd0);
    check({tag, ".break"},    {31'd0, break_seen},   32'd0);
    check({tag, ".overrun"},  {24'd0, overrun_count}, 32'd0);
    check({tag, ".idle"},     {31'd0, line_idle},    32'd0);
  endtask

  initial begin
    int e2;
    int base;
    logic [7:0] exp_q [$];

    // ---- reset ----
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // ---- event while OFF is ignored ----
    send_byte(8'h77, 1'b0);
    tick();
    check("off_ignored", {31'd0, rx_valid}, 32'd0);

    // ---- enable: recv_en one cycle after ctrl_enable ----
    ctrl_enable = 1'b1;
    check("en_delay0", {31'd0, uart_recv_en}, 32'd0);
    tick();
    check("en_delay1", {31'd0, uart_recv_en}, 32'd1);

    // ---- single byte ----
    send_byte(8'hA5, 1'b0);
    check("single_E_valid", {31'd0, rx_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, rx_valid}, 32'd1);
    check("single_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("single_level", {28'd0, fifo_level}, 32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("single_pop_level", {28'd0, fifo_level}, 32'd0);
    check("single_pop_valid", {31'd0, rx_valid}, 32'd0);

    // ---- overrun: 9 bytes into an 8-entry FIFO ----
    for (int i = 1; i <= 9; i++) begin
      send_byte(i[7:0], 1'b0);
      tick();
    end
    check("ovr_level", {28'd0, fifo_level}, 32'd8);
    check("ovr_count", {24'd0, overrun_count}, 32'd1);
    check("ovr_head", {24'd0, rx_data}, 32'h0000_0001);
    // 10th byte arrives while the head is popped: accepted, level stays 8
    send_byte(8'h0A, 1'b0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("ovr_pop_level", {28'd0, fifo_level}, 32'd8);
    check("ovr_pop_count", {24'd0, overrun_count}, 32'd1);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    foreach (exp_q[k]) begin
      check("drain_data", {24'd0, rx_data}, {24'd0, exp_q[k]});
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    check("drain_level", {28'd0, fifo_level}, 32'd0);

    // ---- break ----
    send_byte(8'h00, 1'b1);
    tick();
    uart_break = 1'b0;
    check("brk_seen", {31'd0, break_seen}, 32'd1);
    check("brk_level_drop", {28'd0, fifo_level}, 32'd0);
    check("brk_nb_level", {28'd0, nb_fifo_level}, 32'd1);
    check("brk_nb_data", {24'd0, nb_rx_data}, 32'd0);
    check("brk_nb_seen", {31'd0, nb_break_seen}, 32'd1);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    check("clr_break", {31'd0, break_seen}, 32'd0);
    check("clr_overrun", {24'd0, overrun_count}, 32'd0);
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
    check("brk_nb_flushed", {28'd0, nb_fifo_level}, 32'd0);

    // ---- flush coincident with a push at level 3 ----
    send_byte(8'h11, 1'b0); tick();
    send_byte(8'h22, 1'b0); tick();
    send_byte(8'h33, 1'b0); tick();
    check("fl_pre_level", {28'd0, fifo_level}, 32'd3);
    send_byte(8'h44, 1'b0);
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
    check("fl_level", {28'd0, fifo_level}, 32'd0);
    check("fl_valid", {31'd0, rx_valid}, 32'd0);
    check("fl_overrun", {24'd0, overrun_count}, 32'd0);
    tick();
    check("fl_discarded", {28'd0, fifo_level}, 32'd0);

    // ---- disable during the stop bit ----
    uart_recv_data  = 8'h3C;
    uart_recv_valid = 1'b1;
    repeat (4) tick();
    ctrl_enable = 1'b0;
    tick();
    check("drain_en_on", {31'd0, uart_recv_en}, 32'd1);
    uart_recv_valid = 1'b0;
    tick();
    check("drain_level1", {28'd0, fifo_level}, 32'd1);
    check("drain_data3c", {24'd0, rx_data}, 32'h0000_003C);
    check("drain_en_off", {31'd0, uart_recv_en}, 32'd0);
    send_byte(8'h55, 1'b0);
    tick();
    check("off_late_level", {28'd0, fifo_level}, 32'd1);
    check("off_late_data", {24'd0, rx_data}, 32'h0000_003C);

    // ---- idle: two bytes 20 cycles apart, one pulse ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_enable = 1'b1;
    tick();
    base = pulse_cnt;
    send_byte(8'h61, 1'b0);
    tick();
    repeat (14) tick();
    send_byte(8'h62, 1'b0);
    e2 = cyc;
    // count is 0 in E+1 and reaches 50 in E+51, so the pulse is in E+52
    repeat (120) tick();
    check("idle_one_pulse", pulse_cnt - base, 32'd1);
    check("idle_pulse_cyc", pulse_cyc - e2, 32'd52);

    // ---- reset while the idle counter is running ----
    base = pulse_cnt;
    send_byte(8'h63, 1'b0);
    tick();
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    repeat (70) tick();
    check("midrst_no_pulse", pulse_cnt - base, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
